// File: rtl/log_weight_encoder_pkg.sv
// Shared log-domain weight code definitions: code layout, exponent limits and encoder FSM states.
// Also used by the bit_shifter-side decode checks.
package log_quant_pkg;
  localparam int                  CODE_W    = 4;
  localparam int                  EXP_W     = 3;
  localparam logic [EXP_W-1:0]    EXP_MAX   = 3'd7;
  localparam logic [CODE_W-1:0]   CODE_ZERO = 4'b0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_EMIT
  } enc_state_t;
endpackage

// File: rtl/log_weight_encoder_if.sv
// Weight-in / packed-word-out handshake bundle of the log weight encoder.
interface log_weight_encoder_if #(
    parameter int IN_W = 16,
    parameter int PACK = 8
);
    logic                    i_valid;
    logic                    o_ready;
    logic [IN_W-1:0]         i_weight;
    logic                    i_flush;
    logic                    o_valid;
    logic                    i_ready;
    logic [4*PACK-1:0]       o_word;
    logic [PACK-1:0]         o_skip_mask;
    logic [$clog2(PACK):0]   o_count;

    modport master (
        output i_valid, i_weight, i_flush, i_ready,
        input  o_ready, o_valid, o_word, o_skip_mask, o_count
    );

    modport slave (
        input  i_valid, i_weight, i_flush, i_ready,
        output o_ready, o_valid, o_word, o_skip_mask, o_count
    );
endinterface

// File: rtl/log_weight_encoder_log2_round.sv
// Magnitude to log exponent: leading-one position, rounded half up, saturated at EXP_MAX.
// Magnitudes below ZERO_THR map to exponent 0 (zero weight).
module log2_round
  import log_quant_pkg::*;
#(
    parameter int MAG_W    = 17,
    parameter int ZERO_THR = 1
) (
    input  logic [MAG_W-1:0] mag,
    output logic [EXP_W-1:0] log_exp
);
    localparam int LW = $clog2(MAG_W) + 1;

    logic [LW-1:0] lead;
    logic          rnd;
    logic [LW:0]   sum;

    always_comb begin
        lead = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) lead = i[LW-1:0];
        end
        // The bit just below the leading one decides rounding to the next power of two.
        rnd = 1'b0;
        for (int i = 1; i < MAG_W; i++) begin
            if (lead == i[LW-1:0]) rnd = mag[i-1];
        end
        sum = {1'b0, lead} + (LW+1)'(1) + (LW+1)'(rnd);
        if (mag < MAG_W'(ZERO_THR)) begin
            log_exp = '0;
        end else if (sum > (LW+1)'(EXP_MAX)) begin
            log_exp = EXP_MAX;
        end else begin
            log_exp = sum[EXP_W-1:0];
        end
    end
endmodule

// File: rtl/log_weight_encoder.sv
// Quantises signed weights to {sign, exp} power-of-two codes and packs PACK codes per word,
// with a zero-slot skip mask and flush of partial words.
module log_weight_encoder
  import log_quant_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int PACK     = 8,
    parameter int ZERO_THR = 1
) (
    input logic            clk,
    input logic            reset,
    log_weight_encoder_if.slave bus
);
    localparam int MAG_W  = IN_W + 1;
    localparam int CNT_W  = $clog2(PACK) + 1;
    localparam int WORD_W = CODE_W * PACK;

    enc_state_t              state_q, state_d;
    logic                    vld_p1, sign_p1;
    logic [MAG_W-1:0]        mag_p1;
    logic [EXP_W-1:0]        exp_p1;
    logic [CODE_W-1:0]       code_p1;
    logic [WORD_W-1:0]       acc_p2, word_full;
    logic [CNT_W-1:0]        cnt_p2;
    logic signed [MAG_W-1:0] w_ext;
    logic [MAG_W-1:0]        mag_in;
    logic last_slot, out_free, stall, adv, accept, load_full, load_emit, fire;

    function automatic logic [PACK-1:0] zero_mask(input logic [WORD_W-1:0] w);
        logic [PACK-1:0] m;
        m = '0;
        for (int j = 0; j < PACK; j++) m[j] = (w[CODE_W*j +: CODE_W] == CODE_ZERO);
        return m;
    endfunction

    assign w_ext  = {bus.i_weight[IN_W-1], bus.i_weight};
    assign mag_in = w_ext[MAG_W-1] ? $unsigned(-w_ext) : $unsigned(w_ext);

    log2_round #(.MAG_W(MAG_W), .ZERO_THR(ZERO_THR)) u_round (
        .mag     (mag_p1),
        .log_exp (exp_p1)
    );

    assign code_p1   = (exp_p1 == '0) ? CODE_ZERO : {sign_p1, exp_p1};
    assign last_slot = (cnt_p2 == CNT_W'(PACK - 1));
    assign out_free  = !bus.o_valid || bus.i_ready;
    assign stall     = vld_p1 && last_slot && !out_free;
    assign adv       = vld_p1 && !stall;
    assign bus.o_ready = !reset && (state_q == ST_RUN) && !bus.i_flush && !stall;
    assign accept    = bus.i_valid && bus.o_ready;
    assign load_full = adv && last_slot;
    assign load_emit = (state_q == ST_EMIT) && (cnt_p2 != '0) && out_free;
    assign fire      = bus.o_valid && bus.i_ready;

    always_comb begin
        word_full = acc_p2;
        word_full[CODE_W*int'(cnt_p2) +: CODE_W] = code_p1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.i_flush) state_d = ST_DRAIN;
            ST_DRAIN: if (!vld_p1) state_d = ST_EMIT;
            ST_EMIT:  if ((cnt_p2 == '0) || out_free) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Stage 1: register sign and magnitude of the accepted weight
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       vld_p1 <= 1'b0;
        else if (accept) vld_p1 <= 1'b1;
        else if (adv)    vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p1 <= w_ext[MAG_W-1];
            mag_p1  <= mag_in;
        end
    end

    // Stage 2: slot accumulator; the last slot goes straight to the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end else if (adv) begin
            if (last_slot) begin
                acc_p2 <= '0;
                cnt_p2 <= '0;
            end else begin
                acc_p2 <= word_full;
                cnt_p2 <= cnt_p2 + CNT_W'(1);
            end
        end else if (load_emit) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_valid     <= 1'b0;
            bus.o_word      <= '0;
            bus.o_skip_mask <= '0;
            bus.o_count     <= '0;
        end else if (load_full) begin
            bus.o_valid     <= 1'b1;
            bus.o_word      <= word_full;
            bus.o_skip_mask <= zero_mask(word_full);
            bus.o_count     <= CNT_W'(PACK);
        end else if (load_emit) begin
            bus.o_valid     <= 1'b1;
            bus.o_word      <= acc_p2;
            bus.o_skip_mask <= zero_mask(acc_p2);
            bus.o_count     <= cnt_p2;
        end else if (fire) begin
            bus.o_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_log_weight_encoder.sv
// Randomised and directed bench for log_weight_encoder; two instances (ZERO_THR 1 and 4)
// see the same input stream and are scored against a power-of-two rounding model.
module tb_log_weight_encoder;
    typedef struct {
        logic [31:0] word;
        logic [7:0]  mask;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic [15:0] i_weight = '0;
    logic        ready_hold = 1'b1;
    logic        ready_mode = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        i_ready;
    logic        stall_seen = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          fires_a = 0;
    int          pa[$];
    int          pb[$];
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        last_a;
    exp_t        last_b;

    log_weight_encoder_if #(.IN_W(16), .PACK(8)) ia ();
    log_weight_encoder_if #(.IN_W(16), .PACK(8)) ib ();

    assign i_ready = ready_mode ? rnd_ready : ready_hold;
    assign ia.i_valid = i_valid;  assign ib.i_valid = i_valid;
    assign ia.i_flush = i_flush;  assign ib.i_flush = i_flush;
    assign ia.i_weight = i_weight; assign ib.i_weight = i_weight;
    assign ia.i_ready = i_ready;  assign ib.i_ready = i_ready;

    log_weight_encoder #(.IN_W(16), .PACK(8), .ZERO_THR(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    log_weight_encoder #(.IN_W(16), .PACK(8), .ZERO_THR(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Nearest power of two, ties upward; exponent k+1 encodes magnitude 2^k.
    function automatic int enc(input int w, input int thr);
        int m, k, e;
        m = (w < 0) ? -w : w;
        if (m < thr) return 0;
        k = 0;
        while ((1 << (k + 1)) <= m) k++;
        if (2 * m >= 3 * (1 << k)) k++;
        e = (k + 1 > 7) ? 7 : k + 1;
        return ((w < 0) ? 8 : 0) + e;
    endfunction

    function automatic exp_t pack_codes(input int c[$]);
        exp_t e;
        e.word = '0;
        e.mask = '1;
        e.cnt  = 4'(c.size());
        for (int j = 0; j < c.size(); j++) begin
            e.word = e.word | (32'(c[j]) << (4 * j));
            e.mask[j] = (c[j] == 0);
        end
        return e;
    endfunction

    task automatic model_push(input int w);
        pa.push_back(enc(w, 1));
        pb.push_back(enc(w, 4));
        if (pa.size() == 8) begin
            qa.push_back(pack_codes(pa)); pa.delete();
            qb.push_back(pack_codes(pb)); pb.delete();
        end
    endtask

    task automatic model_flush();
        if (pa.size() > 0) begin
            qa.push_back(pack_codes(pa)); pa.delete();
            qb.push_back(pack_codes(pb)); pb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && i_valid && !i_flush && !ia.o_ready) stall_seen = 1'b1;
        if (!reset && ia.o_valid && i_ready) begin
            exp_t e;
            fires_a++;
            last_a = '{ia.o_word, ia.o_skip_mask, ia.o_count};
            if (qa.size() == 0) check_eq("a_unexpected_word", 64'(qa.size()), 64'd1);
            else begin
                e = qa.pop_front();
                check_eq("a_word", 64'(ia.o_word), 64'(e.word));
                check_eq("a_mask", 64'(ia.o_skip_mask), 64'(e.mask));
                check_eq("a_count", 64'(ia.o_count), 64'(e.cnt));
            end
        end
        if (!reset && ib.o_valid && i_ready) begin
            exp_t e;
            last_b = '{ib.o_word, ib.o_skip_mask, ib.o_count};
            if (qb.size() == 0) check_eq("b_unexpected_word", 64'(qb.size()), 64'd1);
            else begin
                e = qb.pop_front();
                check_eq("b_word", 64'(ib.o_word), 64'(e.word));
                check_eq("b_mask", 64'(ib.o_skip_mask), 64'(e.mask));
                check_eq("b_count", 64'(ib.o_count), 64'(e.cnt));
            end
        end
    end

    // Presents one weight and holds it until accepted; leaves i_valid high for back-to-back use.
    task automatic send(input int w);
        int n = 0;
        i_valid  = 1'b1;
        i_weight = 16'(w);
        while (1) begin
            @(negedge clk);
            if (ia.o_ready) break;
            n++;
            if (n > 200) begin
                check_eq("o_ready_timeout", 64'(ia.o_ready), 64'd1);
                @(posedge clk); #1;
                i_valid = 1'b0;
                return;
            end
        end
        model_push(w);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse();
        i_valid = 1'b0;
        i_flush = 1'b1;
        model_flush();
        @(posedge clk); #1;
        i_flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_a", 64'(qa.size()), 64'd0);
        check_eq("drain_b", 64'(qb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_o_valid"}, 64'(ia.o_valid), 64'd0);
        check_eq({tag, "_o_word"}, 64'(ia.o_word), 64'd0);
        check_eq({tag, "_o_mask"}, 64'(ia.o_skip_mask), 64'd0);
        check_eq({tag, "_o_count"}, 64'(ia.o_count), 64'd0);
        check_eq({tag, "_o_ready"}, 64'(ia.o_ready), 64'd0);
    endtask

    initial begin
        int t1[8] = '{1, 3, -4, 0, 200, -32768, 2, -1};
        int t2[8] = '{1, 0, 3, -4, 100, 0, 2, -1};
        int f0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        reset = 1'b0;
        idle(2);

        foreach (t1[i]) send(t1[i]);
        idle(1);
        wait_drain();

        foreach (t2[i]) send(t2[i]);
        idle(1);
        wait_drain();
        check_eq("t2_word", 64'(last_a.word), 64'h9207B301);
        check_eq("t2_mask", 64'(last_a.mask), 64'h22);
        check_eq("t2_count", 64'(last_a.cnt), 64'd8);

        // Backpressure: output held for 10 cycles right after the first word appears
        stall_seen = 1'b0;
        fork
            for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 2000)) - 1000);
            begin
                int n = 0;
                while (n < 100) begin
                    @(posedge clk); #1;
                    n++;
                    if (ia.o_valid) break;
                end
                ready_hold = 1'b0;
                repeat (10) @(posedge clk);
                #1 ready_hold = 1'b1;
            end
        join
        idle(1);
        check_eq("t3_stall_seen", 64'(stall_seen), 64'd1);
        flush_pulse();
        wait_drain();

        send(5); send(-6); send(7);
        idle(1);
        flush_pulse();
        wait_drain();
        check_eq("t4_word", 64'(last_a.word), 64'h4C3);
        check_eq("t4_mask", 64'(last_a.mask), 64'hF8);
        check_eq("t4_count", 64'(last_a.cnt), 64'd3);

        f0 = fires_a;
        flush_pulse();
        idle(10);
        check_eq("flush0_nofire", 64'(fires_a), 64'(f0));

        send(3); send(-3); send(4);
        idle(1);
        flush_pulse();
        wait_drain();
        check_eq("t6_word", 64'(last_b.word), 64'h300);
        check_eq("t6_mask", 64'(last_b.mask), 64'hFB);
        check_eq("t6_count", 64'(last_b.cnt), 64'd3);

        // Reset with a full word pending and five codes accumulated
        ready_hold = 1'b0;
        for (int i = 0; i < 13; i++) send(int'($urandom_range(1, 300)));
        idle(2);
        check_eq("t5_pre_valid", 64'(ia.o_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        pa.delete(); pb.delete(); qa.delete(); qb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        ready_hold = 1'b1;
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 600)) - 300);
        idle(1);
        wait_drain();
        check_eq("t5_fresh_count", 64'(last_a.cnt), 64'd8);

        ready_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 19));
            if (r == 0) flush_pulse();
            else if (r == 1) idle(1);
            else if (r < 8) send(int'($urandom_range(0, 80)) - 40);
            else begin
                logic signed [15:0] t;
                t = 16'($urandom);
                send(int'(t));
            end
        end
        idle(1);
        flush_pulse();
        ready_mode = 1'b0;
        ready_hold = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
